// File: rtl/prism_sp_puzzle_fifo_switch.sv
// prism_sp_puzzle_fifo_switch
// Routes NCHANNELS shared puzzle FIFOs to either a hardware-puzzle or a
// software-puzzle endpoint. Each channel's read and write directions pick
// their owner independently, and ownership changes pass through a guarded
// handover (BLOCK) so no word is lost, duplicated or split between owners.
//
// Ports
//   clock_i, resetn_i              clock, asynchronous active-low reset
//   sel_r_req_i / sel_w_req_i      requested owner per channel (0=HW, 1=SW)
//   sel_r_o / sel_w_o              current owner per channel
//   busy_r_o / busy_w_o            direction is in handover
//   hw_/sw_rd_en_i, _rd_data_o, _empty_o   consumer-side read ports
//   hw_/sw_wr_en_i, _wr_data_i, _full_o    producer-side write ports
//   fifo_rd_en_o, fifo_rd_data_i, fifo_empty_i   shared FIFO read side
//   fifo_wr_en_o, fifo_wr_data_o, fifo_full_i    shared FIFO write side
//   cnt_{hw,sw}_{r,w}_o            accepted-word counters, 32 bits per channel
//
// Optional feature: define PRISM_SP_PUZZLE_FIFO_SWITCH_STATS_EN to build the
// accepted-word counters; otherwise all cnt_* outputs are tied to zero.
module prism_sp_puzzle_fifo_switch #(
  parameter int                   NCHANNELS    = 4,
  parameter int                   DATA_WIDTH   = 32,
  parameter logic [NCHANNELS-1:0] RESET_SEL_R  = '0,
  parameter logic [NCHANNELS-1:0] RESET_SEL_W  = '0,
  parameter int                   GUARD_CYCLES = 2
) (
  input  logic                            clock_i,
  input  logic                            resetn_i,
  input  logic [NCHANNELS-1:0]            sel_r_req_i,
  input  logic [NCHANNELS-1:0]            sel_w_req_i,
  output logic [NCHANNELS-1:0]            sel_r_o,
  output logic [NCHANNELS-1:0]            sel_w_o,
  output logic [NCHANNELS-1:0]            busy_r_o,
  output logic [NCHANNELS-1:0]            busy_w_o,
  input  logic [NCHANNELS-1:0]            hw_rd_en_i,
  input  logic [NCHANNELS-1:0]            sw_rd_en_i,
  output logic [NCHANNELS*DATA_WIDTH-1:0] hw_rd_data_o,
  output logic [NCHANNELS*DATA_WIDTH-1:0] sw_rd_data_o,
  output logic [NCHANNELS-1:0]            hw_empty_o,
  output logic [NCHANNELS-1:0]            sw_empty_o,
  input  logic [NCHANNELS-1:0]            hw_wr_en_i,
  input  logic [NCHANNELS-1:0]            sw_wr_en_i,
  input  logic [NCHANNELS*DATA_WIDTH-1:0] hw_wr_data_i,
  input  logic [NCHANNELS*DATA_WIDTH-1:0] sw_wr_data_i,
  output logic [NCHANNELS-1:0]            hw_full_o,
  output logic [NCHANNELS-1:0]            sw_full_o,
  output logic [NCHANNELS-1:0]            fifo_rd_en_o,
  input  logic [NCHANNELS*DATA_WIDTH-1:0] fifo_rd_data_i,
  input  logic [NCHANNELS-1:0]            fifo_empty_i,
  output logic [NCHANNELS-1:0]            fifo_wr_en_o,
  output logic [NCHANNELS*DATA_WIDTH-1:0] fifo_wr_data_o,
  input  logic [NCHANNELS-1:0]            fifo_full_i,
  output logic [NCHANNELS*32-1:0]         cnt_hw_r_o,
  output logic [NCHANNELS*32-1:0]         cnt_sw_r_o,
  output logic [NCHANNELS*32-1:0]         cnt_hw_w_o,
  output logic [NCHANNELS*32-1:0]         cnt_sw_w_o
);

  typedef enum logic {ST_ACTIVE = 1'b0, ST_BLOCK = 1'b1} state_e;

  // All 2*NCHANNELS direction FSMs share one body: index d*NCHANNELS+c,
  // d=0 for read, d=1 for write.
  localparam int                     NDIR       = 2 * NCHANNELS;
  localparam logic [NDIR-1:0]        RESET_SEL  = {RESET_SEL_W, RESET_SEL_R};
  localparam logic [3:0]             GUARD_INIT = 4'(GUARD_CYCLES);

  logic [NDIR-1:0] req_all;
  logic [NDIR-1:0] sel_all;
  logic [NDIR-1:0] busy_all;

  assign req_all  = {sel_w_req_i, sel_r_req_i};
  assign sel_r_o  = sel_all[NCHANNELS-1:0];
  assign sel_w_o  = sel_all[NDIR-1:NCHANNELS];
  assign busy_r_o = busy_all[NCHANNELS-1:0];
  assign busy_w_o = busy_all[NDIR-1:NCHANNELS];

  genvar gi, gd;
  generate
    for (gd = 0; gd < 2; gd++) begin : g_dir
      for (gi = 0; gi < NCHANNELS; gi++) begin : g_fsm
        localparam int IDX = gd * NCHANNELS + gi;

        state_e     state_q;
        logic       sel_q;
        logic       tgt_q;
        logic       busy_q;
        logic [3:0] guard_q;

        always_ff @(posedge clock_i or negedge resetn_i) begin
          if (!resetn_i) begin
            state_q <= ST_ACTIVE;
            sel_q   <= RESET_SEL[IDX];
            tgt_q   <= RESET_SEL[IDX];
            busy_q  <= 1'b0;
            guard_q <= '0;
          end else begin
            case (state_q)
              ST_ACTIVE: begin
                // A word accepted on this edge still belongs to the old
                // owner, because routing uses sel_q which changes later.
                if (req_all[IDX] != sel_q) begin
                  tgt_q   <= req_all[IDX];
                  guard_q <= GUARD_INIT;
                  busy_q  <= 1'b1;
                  state_q <= ST_BLOCK;
                end
              end
              ST_BLOCK: begin
                // Request changes are ignored here; the latched target wins
                // and the request is re-compared once back in ACTIVE.
                if (guard_q == 4'd1) begin
                  sel_q   <= tgt_q;
                  busy_q  <= 1'b0;
                  guard_q <= '0;
                  state_q <= ST_ACTIVE;
                end else begin
                  guard_q <= guard_q - 4'd1;
                end
              end
              default: state_q <= ST_ACTIVE;
            endcase
          end
        end

        assign sel_all[IDX]  = sel_q;
        assign busy_all[IDX] = busy_q;
      end
    end

    // Combinational routing. A non-owner, or anyone during BLOCK, sees an
    // empty and full FIFO so it can never move a word.
    for (gi = 0; gi < NCHANNELS; gi++) begin : g_route
      logic r_sw, r_blk, w_sw, w_blk;
      assign r_sw  = sel_all[gi];
      assign r_blk = busy_all[gi];
      assign w_sw  = sel_all[NCHANNELS+gi];
      assign w_blk = busy_all[NCHANNELS+gi];

      assign fifo_rd_en_o[gi] = !r_blk && (r_sw ? sw_rd_en_i[gi] : hw_rd_en_i[gi]);
      assign hw_empty_o[gi]   = r_blk || r_sw  || fifo_empty_i[gi];
      assign sw_empty_o[gi]   = r_blk || !r_sw || fifo_empty_i[gi];
      assign hw_rd_data_o[gi*DATA_WIDTH +: DATA_WIDTH] = fifo_rd_data_i[gi*DATA_WIDTH +: DATA_WIDTH];
      assign sw_rd_data_o[gi*DATA_WIDTH +: DATA_WIDTH] = fifo_rd_data_i[gi*DATA_WIDTH +: DATA_WIDTH];

      assign fifo_wr_en_o[gi] = !w_blk && (w_sw ? sw_wr_en_i[gi] : hw_wr_en_i[gi]);
      assign hw_full_o[gi]    = w_blk || w_sw  || fifo_full_i[gi];
      assign sw_full_o[gi]    = w_blk || !w_sw || fifo_full_i[gi];
      assign fifo_wr_data_o[gi*DATA_WIDTH +: DATA_WIDTH] = w_sw ? sw_wr_data_i[gi*DATA_WIDTH +: DATA_WIDTH]
                                                                : hw_wr_data_i[gi*DATA_WIDTH +: DATA_WIDTH];
    end

`ifdef PRISM_SP_PUZZLE_FIFO_SWITCH_STATS_EN
    // Accepted words are judged by what each side sees, so gating during
    // BLOCK and non-ownership are already folded into empty/full.
    for (gi = 0; gi < NCHANNELS; gi++) begin : g_cnt
      logic [31:0] hw_r_q, sw_r_q, hw_w_q, sw_w_q;

      always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
          hw_r_q <= '0;
          sw_r_q <= '0;
          hw_w_q <= '0;
          sw_w_q <= '0;
        end else begin
          if (hw_rd_en_i[gi] && !hw_empty_o[gi]) hw_r_q <= hw_r_q + 32'd1;
          if (sw_rd_en_i[gi] && !sw_empty_o[gi]) sw_r_q <= sw_r_q + 32'd1;
          if (hw_wr_en_i[gi] && !hw_full_o[gi])  hw_w_q <= hw_w_q + 32'd1;
          if (sw_wr_en_i[gi] && !sw_full_o[gi])  sw_w_q <= sw_w_q + 32'd1;
        end
      end

      assign cnt_hw_r_o[gi*32 +: 32] = hw_r_q;
      assign cnt_sw_r_o[gi*32 +: 32] = sw_r_q;
      assign cnt_hw_w_o[gi*32 +: 32] = hw_w_q;
      assign cnt_sw_w_o[gi*32 +: 32] = sw_w_q;
    end
`else
    assign cnt_hw_r_o = '0;
    assign cnt_sw_r_o = '0;
    assign cnt_hw_w_o = '0;
    assign cnt_sw_w_o = '0;
`endif
  endgenerate

endmodule

// File: tb/tb_prism_sp_puzzle_fifo_switch.sv
// Testbench for prism_sp_puzzle_fifo_switch: table vectors for steady-state
// routing, hand sequences for handover/reset corners, and a randomized run
// checked against an ownership/countdown model of the switch.
module tb_prism_sp_puzzle_fifo_switch;
  localparam int         NCH = 4;
  localparam int         DW  = 32;
  localparam int         G   = 2;
  localparam logic [3:0] RSR = 4'b0010;
  localparam logic [3:0] RSW = 4'b0000;

  logic               clk = 1'b0;
  logic               resetn = 1'b0;
  logic [NCH-1:0]     sel_r_req, sel_w_req, sel_r, sel_w, busy_r, busy_w;
  logic [NCH-1:0]     hw_rd_en, sw_rd_en, hw_empty, sw_empty;
  logic [NCH-1:0]     hw_wr_en, sw_wr_en, hw_full, sw_full;
  logic [NCH-1:0]     fifo_rd_en, fifo_empty, fifo_wr_en, fifo_full;
  logic [NCH*DW-1:0]  hw_rd_data, sw_rd_data, hw_wr_data, sw_wr_data;
  logic [NCH*DW-1:0]  fifo_rd_data, fifo_wr_data;
  logic [NCH*32-1:0]  cnt_hw_r, cnt_sw_r, cnt_hw_w, cnt_sw_w;

  prism_sp_puzzle_fifo_switch #(
    .NCHANNELS(NCH), .DATA_WIDTH(DW), .RESET_SEL_R(RSR), .RESET_SEL_W(RSW), .GUARD_CYCLES(G)
  ) dut (
    .clock_i(clk), .resetn_i(resetn),
    .sel_r_req_i(sel_r_req), .sel_w_req_i(sel_w_req),
    .sel_r_o(sel_r), .sel_w_o(sel_w), .busy_r_o(busy_r), .busy_w_o(busy_w),
    .hw_rd_en_i(hw_rd_en), .sw_rd_en_i(sw_rd_en),
    .hw_rd_data_o(hw_rd_data), .sw_rd_data_o(sw_rd_data),
    .hw_empty_o(hw_empty), .sw_empty_o(sw_empty),
    .hw_wr_en_i(hw_wr_en), .sw_wr_en_i(sw_wr_en),
    .hw_wr_data_i(hw_wr_data), .sw_wr_data_i(sw_wr_data),
    .hw_full_o(hw_full), .sw_full_o(sw_full),
    .fifo_rd_en_o(fifo_rd_en), .fifo_rd_data_i(fifo_rd_data), .fifo_empty_i(fifo_empty),
    .fifo_wr_en_o(fifo_wr_en), .fifo_wr_data_o(fifo_wr_data), .fifo_full_i(fifo_full),
    .cnt_hw_r_o(cnt_hw_r), .cnt_sw_r_o(cnt_sw_r), .cnt_hw_w_o(cnt_hw_w), .cnt_sw_w_o(cnt_sw_w)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: per direction (0=read, 1=write) and channel, who owns
  // it, how many gated cycles remain, and where it is heading.
  int          m_own  [2][NCH];
  int          m_left [2][NCH];
  int          m_tgt  [2][NCH];
  logic [31:0] m_cnt  [4][NCH];   // hw_r, sw_r, hw_w, sw_w

  logic [NCH-1:0]    e_rd_en, e_wr_en, e_hwe, e_swe, e_hwf, e_swf;
  logic [NCH*DW-1:0] e_wdata, wmask;

  typedef struct {
    logic [3:0] fe, ff, hrd, srd, hwr, swr;
    logic [3:0] x_rd_en, x_wr_en, x_hwe, x_swe, x_hwf, x_swf;
  } vec_t;
  vec_t vecs [4];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%h exp=%h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_own[0][c] = int'(RSR[c]);
      m_own[1][c] = int'(RSW[c]);
      for (int d = 0; d < 2; d++) begin
        m_left[d][c] = 0;
        m_tgt[d][c]  = m_own[d][c];
      end
      for (int k = 0; k < 4; k++) m_cnt[k][c] = '0;
    end
  endtask

  task automatic model_comb();
    for (int c = 0; c < NCH; c++) begin
      bit rb, ro, wb, wo;
      rb = (m_left[0][c] > 0);
      ro = (m_own[0][c] == 1);
      wb = (m_left[1][c] > 0);
      wo = (m_own[1][c] == 1);
      e_rd_en[c] = !rb && (ro ? sw_rd_en[c] : hw_rd_en[c]);
      e_hwe[c]   = rb || ro  || fifo_empty[c];
      e_swe[c]   = rb || !ro || fifo_empty[c];
      e_wr_en[c] = !wb && (wo ? sw_wr_en[c] : hw_wr_en[c]);
      e_hwf[c]   = wb || wo  || fifo_full[c];
      e_swf[c]   = wb || !wo || fifo_full[c];
      e_wdata[c*DW +: DW] = wo ? sw_wr_data[c*DW +: DW] : hw_wr_data[c*DW +: DW];
      wmask[c*DW +: DW]   = wb ? '0 : '1;
    end
  endtask

  task automatic check_all();
    logic [3:0]   es_r, es_w, eb_r, eb_w;
    logic [127:0] ec [4];
    for (int c = 0; c < NCH; c++) begin
      es_r[c] = (m_own[0][c] == 1);
      es_w[c] = (m_own[1][c] == 1);
      eb_r[c] = (m_left[0][c] > 0);
      eb_w[c] = (m_left[1][c] > 0);
      for (int k = 0; k < 4; k++) begin
`ifdef PRISM_SP_PUZZLE_FIFO_SWITCH_STATS_EN
        ec[k][c*32 +: 32] = m_cnt[k][c];
`else
        ec[k][c*32 +: 32] = '0;
`endif
      end
    end
    chk("sel_r", 128'(sel_r), 128'(es_r));
    chk("sel_w", 128'(sel_w), 128'(es_w));
    chk("busy_r", 128'(busy_r), 128'(eb_r));
    chk("busy_w", 128'(busy_w), 128'(eb_w));
    chk("fifo_rd_en", 128'(fifo_rd_en), 128'(e_rd_en));
    chk("fifo_wr_en", 128'(fifo_wr_en), 128'(e_wr_en));
    chk("hw_empty", 128'(hw_empty), 128'(e_hwe));
    chk("sw_empty", 128'(sw_empty), 128'(e_swe));
    chk("hw_full", 128'(hw_full), 128'(e_hwf));
    chk("sw_full", 128'(sw_full), 128'(e_swf));
    chk("fifo_wr_data", fifo_wr_data & wmask, e_wdata & wmask);
    chk("hw_rd_data", hw_rd_data, fifo_rd_data);
    chk("sw_rd_data", sw_rd_data, fifo_rd_data);
    chk("cnt_hw_r", cnt_hw_r, ec[0]);
    chk("cnt_sw_r", cnt_sw_r, ec[1]);
    chk("cnt_hw_w", cnt_hw_w, ec[2]);
    chk("cnt_sw_w", cnt_sw_w, ec[3]);
  endtask

  task automatic edge_update();
    if (!resetn) begin
      model_reset();
      return;
    end
    for (int c = 0; c < NCH; c++) begin
      if (hw_rd_en[c] && !e_hwe[c]) m_cnt[0][c] = m_cnt[0][c] + 32'd1;
      if (sw_rd_en[c] && !e_swe[c]) m_cnt[1][c] = m_cnt[1][c] + 32'd1;
      if (hw_wr_en[c] && !e_hwf[c]) m_cnt[2][c] = m_cnt[2][c] + 32'd1;
      if (sw_wr_en[c] && !e_swf[c]) m_cnt[3][c] = m_cnt[3][c] + 32'd1;
      for (int d = 0; d < 2; d++) begin
        int req;
        req = (d == 0) ? int'(sel_r_req[c]) : int'(sel_w_req[c]);
        if (m_left[d][c] > 0) begin
          m_left[d][c]--;
          if (m_left[d][c] == 0) m_own[d][c] = m_tgt[d][c];
        end else if (req != m_own[d][c]) begin
          m_tgt[d][c]  = req;
          m_left[d][c] = G;
        end
      end
    end
  endtask

  // Inputs are changed just after a rising edge; checks happen 1 after the
  // falling edge; the model advances right after the next rising edge.
  task automatic mid_check();
    @(negedge clk);
    #1;
    model_comb();
    check_all();
  endtask

  task automatic edge_step();
    @(posedge clk);
    edge_update();
    #1;
  endtask

  task automatic idle_inputs();
    hw_rd_en = '0; sw_rd_en = '0; hw_wr_en = '0; sw_wr_en = '0;
    fifo_empty = '0; fifo_full = '0;
  endtask

  task automatic rand_data();
    for (int c = 0; c < NCH; c++) begin
      hw_wr_data[c*DW +: DW]   = $urandom;
      sw_wr_data[c*DW +: DW]   = $urandom;
      fifo_rd_data[c*DW +: DW] = $urandom;
    end
  endtask

  initial begin
    int bcnt, viol, saw1;

    vecs[0] = '{fe:4'b0000, ff:4'b0000, hrd:4'b1111, srd:4'b1111, hwr:4'b1111, swr:4'b0000,
                x_rd_en:4'b1111, x_wr_en:4'b1111, x_hwe:4'b0010, x_swe:4'b1101, x_hwf:4'b0000, x_swf:4'b1111};
    vecs[1] = '{fe:4'b1111, ff:4'b1111, hrd:4'b0101, srd:4'b0000, hwr:4'b0000, swr:4'b1111,
                x_rd_en:4'b0101, x_wr_en:4'b0000, x_hwe:4'b1111, x_swe:4'b1111, x_hwf:4'b1111, x_swf:4'b1111};
    vecs[2] = '{fe:4'b1010, ff:4'b0110, hrd:4'b0000, srd:4'b1111, hwr:4'b0011, swr:4'b1100,
                x_rd_en:4'b0010, x_wr_en:4'b0011, x_hwe:4'b1010, x_swe:4'b1111, x_hwf:4'b0110, x_swf:4'b1111};
    vecs[3] = '{fe:4'b0000, ff:4'b0000, hrd:4'b0010, srd:4'b1101, hwr:4'b0000, swr:4'b0000,
                x_rd_en:4'b0000, x_wr_en:4'b0000, x_hwe:4'b0010, x_swe:4'b1101, x_hwf:4'b0000, x_swf:4'b1111};

    // Reset state
    sel_r_req = RSR; sel_w_req = RSW;
    idle_inputs();
    rand_data();
    model_reset();
    mid_check();
    chk("rst_sel_r", 128'(sel_r), 128'(4'b0010));
    chk("rst_ch1_sw_empty", 128'(sw_empty[1]), 128'(fifo_empty[1]));
    chk("rst_ch1_hw_empty", 128'(hw_empty[1]), 128'(1'b1));
    edge_step();
    resetn = 1'b1;
    $display("[TB] reset released sel_r=%b sel_w=%b", sel_r, sel_w);

    // Steady-state routing table
    for (int i = 0; i < 4; i++) begin
      fifo_empty = vecs[i].fe; fifo_full = vecs[i].ff;
      hw_rd_en = vecs[i].hrd; sw_rd_en = vecs[i].srd;
      hw_wr_en = vecs[i].hwr; sw_wr_en = vecs[i].swr;
      rand_data();
      @(negedge clk);
      #1;
      chk("vec_rd_en", 128'(fifo_rd_en), 128'(vecs[i].x_rd_en));
      chk("vec_wr_en", 128'(fifo_wr_en), 128'(vecs[i].x_wr_en));
      chk("vec_hw_empty", 128'(hw_empty), 128'(vecs[i].x_hwe));
      chk("vec_sw_empty", 128'(sw_empty), 128'(vecs[i].x_swe));
      chk("vec_hw_full", 128'(hw_full), 128'(vecs[i].x_hwf));
      chk("vec_sw_full", 128'(sw_full), 128'(vecs[i].x_swf));
      model_comb();
      check_all();
      $display("[TB] vec %0d rd_en=%b wr_en=%b hw_empty=%b sw_empty=%b", i, fifo_rd_en, fifo_wr_en, hw_empty, sw_empty);
      edge_step();
    end

    // ch0 HW write while SW also asserts write
    idle_inputs();
    rand_data();
    hw_wr_en = 4'b0001; sw_wr_en = 4'b0001;
    hw_wr_data[31:0] = 32'hA5A5_0001; sw_wr_data[31:0] = 32'h5A5A_FFFF;
    mid_check();
    chk("hw_wr_data_ch0", 128'(fifo_wr_data[31:0]), 128'(32'hA5A5_0001));
    chk("hw_wr_en_ch0", 128'(fifo_wr_en[0]), 128'(1'b1));
    $display("[TB] ch0 hw write data=%h", fifo_wr_data[31:0]);
    edge_step();

    // sel_w_req[2] 0->1 with both producers writing
    idle_inputs();
    hw_wr_en = 4'b1111; sw_wr_en = 4'b1111;
    sel_w_req[2] = 1'b1;
    bcnt = 0; viol = 0; saw1 = 0;
    for (int k = 0; k < 5; k++) begin
      rand_data();
      mid_check();
      if (busy_w[2]) begin
        bcnt++;
        if (fifo_wr_en[2] || !hw_full[2] || !sw_full[2]) viol++;
      end
      if (k == 3) saw1 = int'(sel_w[2]);
      edge_step();
    end
    chk("w2_busy_cycles", 128'(bcnt), 128'(G));
    chk("w2_gating", 128'(viol), 128'(0));
    chk("w2_sel_third", 128'(saw1), 128'(1));
    $display("[TB] sel_w[2] handover busy=%0d sel_w=%b", bcnt, sel_w);

    // sel_r_req[3] 0->1->0 inside BLOCK
    idle_inputs();
    hw_rd_en = 4'b1111; sw_rd_en = 4'b1111;
    sel_r_req[3] = 1'b1;
    bcnt = 0; viol = 0; saw1 = 0;
    for (int k = 0; k < 8; k++) begin
      rand_data();
      mid_check();
      if (busy_r[3]) begin
        bcnt++;
        if (fifo_rd_en[3]) viol++;
      end
      if (sel_r[3]) saw1 = 1;
      edge_step();
      if (k == 0) sel_r_req[3] = 1'b0;
    end
    chk("r3_busy_total", 128'(bcnt), 128'(2 * G));
    chk("r3_gating", 128'(viol), 128'(0));
    chk("r3_saw_sw", 128'(saw1), 128'(1));
    chk("r3_final_sel", 128'(sel_r[3]), 128'(1'b0));
    $display("[TB] sel_r[3] revert busy=%0d sel_r=%b", bcnt, sel_r);

    // Reset dropped mid-BLOCK on ch1 write direction
    idle_inputs();
    hw_wr_en = 4'b1111;
    sel_w_req[1] = 1'b1;
    mid_check();
    edge_step();
    mid_check();
    chk("rst_pre_busy", 128'(busy_w[1]), 128'(1'b1));
    edge_step();
    #2;
    resetn = 1'b0;
    #1;
    chk("rst_mid_busy_w", 128'(busy_w), 128'(4'b0000));
    chk("rst_mid_sel_w", 128'(sel_w), 128'(RSW));
    chk("rst_mid_sel_r", 128'(sel_r), 128'(RSR));
    chk("rst_mid_wr_en", 128'(fifo_wr_en[1]), 128'(1'b1));
    chk("rst_mid_cnt", 128'(cnt_hw_w), 128'(0));
    model_reset();
    sel_r_req = RSR; sel_w_req = RSW;
    mid_check();
    edge_step();
    resetn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      rand_data();
      mid_check();
      edge_step();
    end
    $display("[TB] reset mid-block recovered sel_w=%b busy_w=%b", sel_w, busy_w);

    // Randomized traffic with occasional ownership requests
    for (int k = 0; k < 300; k++) begin
      hw_rd_en = 4'($urandom); sw_rd_en = 4'($urandom);
      hw_wr_en = 4'($urandom); sw_wr_en = 4'($urandom);
      fifo_empty = 4'($urandom) & 4'($urandom);
      fifo_full  = 4'($urandom) & 4'($urandom);
      if ($urandom_range(0, 7) == 0) sel_r_req = sel_r_req ^ 4'($urandom);
      if ($urandom_range(0, 7) == 0) sel_w_req = sel_w_req ^ 4'($urandom);
      rand_data();
      mid_check();
      $display("[TB] rnd %0d req_r=%b req_w=%b sel_r=%b sel_w=%b busy_r=%b busy_w=%b",
               k, sel_r_req, sel_w_req, sel_r, sel_w, busy_r, busy_w);
      edge_step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
